// File: rtl/nibble_mayor_seq.sv
// Job sequencer for the shared 2-input nibble comparator: buffers a burst of 1..MAX_N nibbles,
// walks it through the comparator and returns max/count. Optional macro NMS_SELF_CHECK_EN adds cmp_err.
module nibble_mayor_seq #(
  parameter int MAX_N   = 8,
  parameter int CNT_W   = 4,
  parameter int CMP_LAT = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic [3:0]       cmp_mayor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_max,
  output logic [CNT_W-1:0] res_count,
  output logic             busy
`ifdef NMS_SELF_CHECK_EN
  ,
  output logic             cmp_err
`endif
);

  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int WC_W  = (CMP_LAT < 1) ? 1 : $clog2(CMP_LAT + 1);
  localparam logic [CNT_W-1:0] MAX_N_C = CNT_W'(MAX_N);
  localparam logic [WC_W-1:0]  LAT_C   = WC_W'(CMP_LAT);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [CNT_W-1:0] idx_r, idx_s;
  logic [WC_W-1:0]  wcnt_r, wcnt_s;
  logic [3:0]       acc_r, acc_s;
  logic [3:0]       cmp_a_r, cmp_a_s;
  logic [3:0]       cmp_b_r, cmp_b_s;
  logic [3:0]       buf_r [MAX_N];
  logic             wr_en_s;
  logic             accept_s;
  logic             sample_s;

  logic             in_ready_r;
  logic             busy_r;
  logic             res_valid_r;
  logic [3:0]       res_max_r;
  logic [CNT_W-1:0] res_count_r;

  assign accept_s = in_valid & in_ready_r & (state_r == LOAD);
  assign sample_s = (state_r == WAIT) && (wcnt_r == LAT_C);

  // Next-state and datapath decode for the sequencer FSM.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    idx_s   = idx_r;
    wcnt_s  = wcnt_r;
    acc_s   = acc_r;
    cmp_a_s = cmp_a_r;
    cmp_b_s = cmp_b_r;
    wr_en_s = 1'b0;
    case (state_r)
      LOAD: begin
        if (accept_s) begin
          count_s = count_r + CNT_W'(1);
          wr_en_s = 1'b1;
          // The MAX_N-th beat closes the job regardless of in_last.
          if (in_last || (count_s == MAX_N_C)) begin
            if (count_r == CNT_W'(0)) begin
              acc_s   = in_data;
              state_s = RESULT;
            end else begin
              acc_s   = buf_r[0];
              idx_s   = CNT_W'(1);
              state_s = ISSUE;
            end
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      ISSUE: begin
        cmp_a_s = acc_r;
        cmp_b_s = buf_r[idx_r[IDX_W-1:0]];
        wcnt_s  = WC_W'(0);
        state_s = WAIT;
      end
      WAIT: begin
        if (sample_s) begin
          acc_s = cmp_mayor;
          idx_s = idx_r + CNT_W'(1);
          if (idx_r == (count_r - CNT_W'(1))) begin
            state_s = RESULT;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          wcnt_s  = wcnt_r + WC_W'(1);
          state_s = WAIT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          count_s = CNT_W'(0);
          state_s = LOAD;
        end else begin
          state_s = RESULT;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= LOAD;
      count_r     <= CNT_W'(0);
      idx_r       <= CNT_W'(0);
      wcnt_r      <= WC_W'(0);
      acc_r       <= 4'd0;
      cmp_a_r     <= 4'd0;
      cmp_b_r     <= 4'd0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_max_r   <= 4'd0;
      res_count_r <= CNT_W'(0);
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      idx_r       <= idx_s;
      wcnt_r      <= wcnt_s;
      acc_r       <= acc_s;
      cmp_a_r     <= cmp_a_s;
      cmp_b_r     <= cmp_b_s;
      in_ready_r  <= (state_s == LOAD);
      busy_r      <= (state_s != LOAD);
      res_valid_r <= (state_s == RESULT);
      res_max_r   <= (state_s == RESULT) ? acc_s : 4'd0;
      res_count_r <= (state_s == RESULT) ? count_s : CNT_W'(0);
    end
  end

  // Burst buffer; contents are don't-care after reset, so no reset branch.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      buf_r[count_r[IDX_W-1:0]] <= in_data;
    end
  end

`ifdef NMS_SELF_CHECK_EN
  function automatic logic [3:0] max_nib(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? a : b;
  endfunction

  logic cmp_err_r;

  // Sticky flag: comparator result disagreed with the locally computed maximum.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmp_err_r <= 1'b0;
    end else if (sample_s && (cmp_mayor != max_nib(acc_r, buf_r[idx_r[IDX_W-1:0]]))) begin
      cmp_err_r <= 1'b1;
    end else begin
      cmp_err_r <= cmp_err_r;
    end
  end

  assign cmp_err = cmp_err_r;
`endif

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign res_max   = res_max_r;
  assign res_count = res_count_r;
  assign cmp_a     = cmp_a_r;
  assign cmp_b     = cmp_b_r;

endmodule

// File: tb/tb_nibble_mayor_seq.sv
// Self-checking bench for nibble_mayor_seq: CMP_LAT-deep behavioural max model as the comparator,
// job-level reference model checked every cycle, directed cases plus randomized jobs.
module tb_nibble_mayor_seq;
  localparam int MAX_N   = 8;
  localparam int CNT_W   = 4;
  localparam int CMP_LAT = 4;
  localparam int COST    = CMP_LAT + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [3:0]       in_data = 4'd0;
  logic             res_ready = 1'b0;
  logic             in_ready;
  logic [3:0]       cmp_a, cmp_b, cmp_mayor;
  logic             res_valid;
  logic [3:0]       res_max;
  logic [CNT_W-1:0] res_count;
  logic             busy;
`ifdef NMS_SELF_CHECK_EN
  logic             cmp_err;
`endif

  nibble_mayor_seq #(.MAX_N(MAX_N), .CNT_W(CNT_W), .CMP_LAT(CMP_LAT)) dut (
    .CLK(clk), .RESET(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_mayor(cmp_mayor),
    .res_valid(res_valid), .res_ready(res_ready), .res_max(res_max), .res_count(res_count),
    .busy(busy)
`ifdef NMS_SELF_CHECK_EN
    , .cmp_err(cmp_err)
`endif
  );

  always #5 clk = ~clk;

  // Comparator stand-in: max(cmp_a,cmp_b) delayed CMP_LAT cycles, optionally forced to 0.
  bit         force_zero = 1'b0;
  bit         fault_job  = 1'b0;
  logic [3:0] pipe [CMP_LAT];
  assign cmp_mayor = pipe[CMP_LAT-1];
  always @(posedge clk) begin
    pipe[0] <= force_zero ? 4'd0 : ((cmp_a >= cmp_b) ? cmp_a : cmp_b);
    for (int i = 1; i < CMP_LAT; i++) pipe[i] <= pipe[i-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job-level reference: collect beats, then the result appears (N-1)*COST edges after the last one.
  typedef enum {M_LOAD, M_CALC, M_RES} mmode_t;
  mmode_t mode = M_LOAD;
  int     q[$];
  int     m_left = 0, m_max = 0, m_cnt = 0;
  bit     m_ready = 1'b0, m_started = 1'b0, m_in_reset = 1'b0;

  task automatic model_step();
    if (rst) begin
      mode = M_LOAD; q.delete(); m_ready = 1'b0; m_started = 1'b1; m_in_reset = 1'b1;
    end else begin
      m_in_reset = 1'b0;
      case (mode)
        M_LOAD: if (m_ready && in_valid) begin
          q.push_back(int'(in_data));
          if (in_last || q.size() == MAX_N) begin
            m_cnt = q.size();
            m_max = 0;
            foreach (q[i]) if (q[i] > m_max) m_max = q[i];
            m_left = (m_cnt - 1) * COST;
            mode = (m_left == 0) ? M_RES : M_CALC;
          end
        end
        M_CALC: begin
          m_left--;
          if (m_left == 0) mode = M_RES;
        end
        M_RES: if (res_ready) begin
          mode = M_LOAD; q.delete();
        end
        default: mode = M_LOAD;
      endcase
      m_ready = (mode == M_LOAD);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of the DUT against the reference, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_started) begin
      check("in_ready", in_ready, m_ready);
      check("busy", busy, mode != M_LOAD);
      check("res_valid", res_valid, mode == M_RES);
      if (mode == M_RES) begin
        if (!fault_job) check("res_max", res_max, m_max);
        check("res_count", res_count, m_cnt);
      end
      if (m_in_reset) begin
        check("rst_res_max", res_max, 0);
        check("rst_res_count", res_count, 0);
        check("rst_cmp_a", cmp_a, 0);
        check("rst_cmp_b", cmp_b, 0);
`ifdef NMS_SELF_CHECK_EN
        check("rst_cmp_err", cmp_err, 0);
`endif
      end
    end
  end

  int e0 = 0;

  task automatic send(input logic [3:0] d, input bit last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("send_bound", n < 100, 1);
    @(posedge clk); #1 e0 = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = 4'd0;
  endtask

  task automatic wait_result(output int lat);
    int n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    check("result_bound", n < 300, 1);
    lat = cyc - e0;
  endtask

  task automatic take();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  int lat;
  logic [3:0] a_before, b_before;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);

    // 3,9,5 -> 9 / 3, twelve cycles after the last beat
    send(4'd3, 1'b0); send(4'd9, 1'b0); send(4'd5, 1'b1);
    wait_result(lat);
    check("j395_lat", lat, 12);
    check("j395_max", res_max, 9);
    check("j395_cnt", res_count, 3);
    take();

    // single beat: result on E0 without touching the comparator operands
    a_before = cmp_a; b_before = cmp_b;
    send(4'd7, 1'b1);
    wait_result(lat);
    check("j7_lat", lat, 0);
    check("j7_max", res_max, 7);
    check("j7_cnt", res_count, 1);
    check("j7_cmp_a", cmp_a, a_before);
    check("j7_cmp_b", cmp_b, b_before);
    take();

    // 1..8 without in_last: overflow closes the job; beats offered while busy are dropped
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
    check("ovf_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 4'hF;
    repeat (10) @(negedge clk);
    in_valid = 1'b0; in_data = 4'd0;
    wait_result(lat);
    check("ovf_lat", lat, 7 * COST);
    check("ovf_max", res_max, 8);
    check("ovf_cnt", res_count, 8);
    take();

    // A,A with res_ready held low
    send(4'hA, 1'b0); send(4'hA, 1'b1);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_max", res_max, 10);
      check("hold_cnt", res_count, 2);
      check("hold_in_ready", in_ready, 0);
    end
    take();
    check("hold_release_in_ready", in_ready, 1);

    // reset during WAIT of {2,F}: job aborted
    send(4'd2, 1'b0); send(4'hF, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_res_valid", res_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_cmp_a", cmp_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_recover_in_ready", in_ready, 1);
    send(4'd4, 1'b0); send(4'd1, 1'b1);
    wait_result(lat);
    check("j41_max", res_max, 4);
    check("j41_cnt", res_count, 2);
    take();

    // randomized jobs, max tracked while the beats are generated
    for (int j = 0; j < 30; j++) begin
      int len, mx, gap;
      logic [3:0] d;
      bit last;
      len = $urandom_range(1, MAX_N);
      mx = 0;
      for (int k = 0; k < len; k++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        d = 4'($urandom_range(0, 15));
        if (int'(d) > mx) mx = int'(d);
        last = (k == len - 1) && ((len < MAX_N) || ($urandom_range(0, 1) == 1));
        send(d, last);
      end
      wait_result(lat);
      check("rnd_lat", lat, (len - 1) * COST);
      check("rnd_max", res_max, mx);
      check("rnd_cnt", res_count, len);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      take();
    end

`ifdef NMS_SELF_CHECK_EN
    check("err_initial", cmp_err, 0);
    force_zero = 1'b1; fault_job = 1'b1;
    send(4'd6, 1'b0); send(4'd3, 1'b1);
    wait_result(lat);
    check("err_set", cmp_err, 1);
    take();
    force_zero = 1'b0; fault_job = 1'b0;
    send(4'd1, 1'b0); send(4'd2, 1'b1);
    wait_result(lat);
    check("err_sticky_max", res_max, 2);
    check("err_sticky", cmp_err, 1);
    take();
    rst = 1'b1;
    @(negedge clk);
    check("err_cleared", cmp_err, 0);
    rst = 1'b0;
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
